// File: rtl/adder_pkg.sv
// Shared definitions for the time-multiplexed 64-bit adder sequencer.
package adder_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_SLICE_W = 16;
    localparam int DEF_NSLICE  = DEF_DATA_W / DEF_SLICE_W;
    localparam int DEF_IDX_W   = $clog2(DEF_NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-slice configuration still needs a one-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE_W-bit adder slice shared by every pass of the sequencer.
module adder_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

endmodule

// File: rtl/adder64_seq_ctrl.sv
// Multi-cycle add/subtract: one shared slice, low slice first, valid/ready on both sides.
// Optional macro ADDER_OVF_EN adds a registered signed-overflow output out_ovf.
module adder64_seq_ctrl
    import adder_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
`ifdef ADDER_OVF_EN
    output logic              out_ovf,
`endif
    output logic              busy
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((DATA_W % SLICE_W) != 0) begin : g_bad_width
            $fatal(1, "adder64_seq_ctrl: DATA_W must be a multiple of SLICE_W");
        end
    endgenerate

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  a_q, b_q, sum_q;
    logic [IDX_W-1:0]   cnt_q;
    logic               carry_q, cout_q;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               last_pass;

    assign last_pass = (cnt_q == LAST_IDX);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    // Operands shift right each pass, so the active slice is always the low bits.
    adder_slice #(.W(SLICE_W)) u_slice (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_pass) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so only the operand and initial carry differ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? 1'b1 : in_cin;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> SLICE_W;
            b_q     <= b_q >> SLICE_W;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
            for (int i = 0; i < NSLICE; i++) begin
                if (cnt_q == IDX_W'(i)) sum_q[i*SLICE_W +: SLICE_W] <= slice_s;
            end
            if (last_pass) cout_q <= slice_cout;
        end
    end

`ifdef ADDER_OVF_EN
    logic msb_cin;
    logic ovf_q;

    // Carry into the top bit is recovered from its sum bit and operand bits.
    assign msb_cin = a_q[SLICE_W-1] ^ b_q[SLICE_W-1] ^ slice_s[SLICE_W-1];
    assign out_ovf = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ovf_q <= 1'b0;
        else if (state == RUN && last_pass)  ovf_q <= msb_cin ^ slice_cout;
    end
`endif

endmodule

// File: tb/tb_adder64_seq_ctrl.sv
// Self-checking bench for adder64_seq_ctrl: directed table, random vectors, backpressure and reset-abort.
module tb_adder64_seq_ctrl;

    localparam int LATENCY = 4;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [63:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, busy;
`ifdef ADDER_OVF_EN
    logic        out_ovf;
`endif

    int checks = 0;
    int fails  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    adder64_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef ADDER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the integer definition of add/subtract.
    function automatic void refModel(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                     input logic sub, output logic [63:0] s, output logic co,
                                     output logic ov);
        logic [64:0] wide;
        if (sub) begin
            s  = a - b;
            co = (a >= b);
            ov = (a[63] != b[63]) && (s[63] != a[63]);
        end else begin
            wide = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            s    = wide[63:0];
            co   = wide[64];
            ov   = (a[63] == b[63]) && (s[63] != a[63]);
        end
    endfunction

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        @(negedge clk);
        checkOutput("in_ready_before_request", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_cin   = 1'($urandom);
        in_sub   = 1'($urandom);
    endtask

    task automatic waitResult(output int lat);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (out_valid) lat = i - 1;
        end
    endtask

    task automatic checkResult(input string name, input logic [63:0] es, input logic ec, input logic eo);
        int lat;
        waitResult(lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'(LATENCY));
        checkOutput({name, "_sum"}, out_sum, es);
        checkOutput({name, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
`ifdef ADDER_OVF_EN
        checkOutput({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, eo});
`else
        if (eo === 1'bx) checkOutput({name, "_ovf_expected_known"}, 64'd1, 64'd0);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, "_valid_dropped"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [63:0] s, s2, na, nb;
        logic        co, ov, co2, ov2, seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;

        vecs.push_back('{"ripple",   64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0});
        vecs.push_back('{"wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0,                  1'b1, 1'b0});
        vecs.push_back('{"sub5m7",   64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        vecs.push_back('{"sub7m5",   64'd7, 64'd5, 1'b0, 1'b1, 64'd2,                   1'b1, 1'b0});
        vecs.push_back('{"sub0m1",   64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{"signovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vecs.push_back('{"addcin",   64'd1, 64'd1, 1'b1, 1'b0, 64'd3,                   1'b0, 1'b0});
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            v.name = "random";
            v.a    = {$urandom, $urandom};
            v.b    = (i % 4 == 0) ? ~v.a : {$urandom, $urandom};
            v.cin  = 1'($urandom);
            v.sub  = 1'($urandom);
            refModel(v.a, v.b, v.cin, v.sub, v.exp_sum, v.exp_cout, v.exp_ovf);
            vecs.push_back(v);
        end

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_busy",      {63'd0, busy},      64'd0);
        checkOutput("reset_sum",       out_sum,            64'd0);
        checkOutput("reset_cout",      {63'd0, out_cout},  64'd0);
        rst_n = 1'b1;

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            checkResult(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Backpressure: result must hold while a new request waits at the input.
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        refModel(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, s, co, ov);
        begin
            int lat;
            waitResult(lat);
            checkOutput("bp_latency", 64'(lat), 64'(LATENCY));
        end
        na = {$urandom, $urandom};
        nb = {$urandom, $urandom};
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_a = na; in_b = nb; in_cin = 1'b0; in_sub = 1'b1;
            checkOutput("bp_valid_held", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_sum_held",   out_sum,            s);
            checkOutput("bp_cout_held",  {63'd0, out_cout},  {63'd0, co});
            checkOutput("bp_in_ready",   {63'd0, in_ready},  64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_after_hs_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_after_hs_ready", {63'd0, in_ready},  64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = '0; in_b = '0;
        checkOutput("bp_second_accepted", {63'd0, busy}, 64'd1);
        refModel(na, nb, 1'b0, 1'b1, s2, co2, ov2);
        checkResult("bp_second", s2, co2, ov2);

        // Reset two passes into an operation must abort cleanly.
        applyStimulus(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("abort_busy",      {63'd0, busy},      64'd0);
        checkOutput("abort_sum",       out_sum,            64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("abort_no_spurious_valid", {63'd0, seen}, 64'd0);
        applyStimulus(64'd100, 64'd23, 1'b0, 1'b0);
        checkResult("after_abort", 64'd123, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adder64_seq_ctrl.md
Name: adder64_seq_ctrl

Overview:
Multi-cycle sequencer that computes 64-bit add/subtract by time-multiplexing one 16-bit ripple adder slice over four cycles, low byte-slice first.
It trades the area of the four-slice 64-bit adder for latency.
It is used on paths that are not throughput-critical (address offset, counter update).
Upstream and downstream connect through valid/ready handshakes.

Parameters:
DATA_W, 64, operand/result width; must be a multiple of SLICE_W (elaboration-time check, fatal on violation)
SLICE_W, 16, width of the shared adder slice
NSLICE, DATA_W/SLICE_W (derived, localparam), number of slice passes per operation

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  controller can accept a request
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_cin  in  1  carry-in (add only)
in_sub  in  1  1 = A - B, 0 = A + B + cin
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sum  out  DATA_W  result
out_cout  out  1  carry out of MSB slice (sub: 1 = no borrow)
busy  out  1  operation in flight (RUN or DONE)

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, slice counter=0, carry=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch A; latch B, or ~B when in_sub. Carry reg = in_sub ? 1 : in_cin (in_cin ignored for sub). cnt=0. Go to RUN.
  - RUN: in_ready=0. Each cycle:
    - slice adds A[cnt*SLICE_W +: SLICE_W] + B[same] + carry;
    - sum slice written into the result register at the same offset;
    - carry reg <= slice cout; cnt++.
    - After the pass with cnt==NSLICE-1: out_cout <= slice cout, go to DONE.
  - DONE: out_valid=1; out_sum/out_cout held stable until out_ready. On out_ready: out_valid deasserts next cycle, state=IDLE.
- Latency: request accepted at edge T → out_valid high after edge T+NSLICE (4 cycles default). Minimum issue interval NSLICE+2 cycles with out_ready tied high.
- in_ready is 0 in RUN and DONE. There is no overlap of a new request with a pending result. in_valid during busy is ignored; the requester holds it.
- Arithmetic: modulo 2^DATA_W wrap-around. All-ones + 1 gives sum=0, cout=1.
- Sub: 0 - 1 gives sum=all ones, cout=0.
- Inputs are sampled only at acceptance. Changes to in_a/in_b afterward have no effect.
- out_sum retains the last result after handshake until the next DONE (not cleared); the bench checks it only while out_valid.
- Reset mid-operation: immediate abort, all outputs to reset values, no spurious out_valid after release.

Optional Feature:
ADDER_OVF_EN
- Defined: extra output out_ovf (1 bit), two's-complement signed overflow. It equals the XOR of the carry into and out of the MSB of the top slice. It is registered with out_cout, valid with out_valid, and resets to 0.
- Undefined: port absent, no overflow logic.

Decomposition:
- Shared package adder_pkg:
  - DATA_W/SLICE_W defaults;
  - state enum typedef (IDLE, RUN, DONE);
  - slice index width constant $clog2(NSLICE).
- Natural sub-module: adder_slice. It is a purely combinational SLICE_W-bit ripple adder (a, b, cin → s, cout), instantiated once. It is the same slice type the datapath already uses, re-wrapped under this name.

Test Plan:
- Reset mid-RUN: after 2 slice cycles assert rst_n=0 → out_valid=0, in_ready=1 immediately; no out_valid after release until a new request.
- Add with ripple across all slices: A=64'h0000_FFFF_FFFF_FFFF, B=1, cin=0 → out_sum=64'h0001_0000_0000_0000, cout=0, out_valid exactly 4 cycles after accept.
- Wrap-around: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 → sum=0, cout=1; with ADDER_OVF_EN, ovf=0.
- Subtract: A=5, B=7, in_sub=1, in_cin=1 (ignored) → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0. A=7, B=5 → sum=2, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands → out_valid, sum and cout stable, in_ready=0, second request accepted only in the cycle after the handshake plus return to IDLE.
- Signed overflow (ADDER_OVF_EN): A=64'h7FFF_FFFF_FFFF_FFFF, B=1 → sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
